// File: rtl/sram_array_pkg.sv
// Shared types and width helpers for the masked-write SRAM array and its init controller.
package sram_array_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  // A one-word array still needs a one-bit address port.
  function automatic int calc_aw(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int calc_mw(input int data_width, input int mask_gran);
    return data_width / mask_gran;
  endfunction

endpackage

// File: rtl/sram_array_init_ctrl.sv
// Init FSM for the SRAM array: sweeps INIT_VALUE over every word after reset, then
// hands the array port over to user requests.
module sram_array_init_ctrl
  import sram_array_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int DATA_WIDTH = 8,
  parameter int MASK_GRAN = 8,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int AW = calc_aw(DEPTH),
  localparam int MW = calc_mw(DATA_WIDTH, MASK_GRAN)
) (
  input  logic                  RW0_clk,
  input  logic                  reset,
  input  logic [AW-1:0]         req_addr,
  input  logic                  req_en,
  input  logic                  req_wmode,
  input  logic [MW-1:0]         req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [AW-1:0]         arr_addr,
  output logic                  arr_we,
  output logic                  arr_re,
  output logic [MW-1:0]         arr_wmask,
  output logic [DATA_WIDTH-1:0] arr_wdata,
  output logic                  init_done
);

  // The counter runs one past the last address; that extra INIT cycle is what
  // places the rise of init_done DEPTH+1 cycles after reset release.
  localparam logic [AW:0] CNT_END = (AW+1)'(DEPTH);

  init_state_e state;
  logic [AW:0] init_cnt;
  logic        init_active;

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      if (INIT_ON_RESET == 0 || init_cnt == CNT_END) begin
        state <= READY;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  assign init_done   = (state == READY);
  assign init_active = (state == INIT) && (INIT_ON_RESET != 0) && (init_cnt != CNT_END);

  always_comb begin
    arr_addr  = req_addr;
    arr_we    = init_done & req_en & req_wmode;
    arr_re    = init_done & req_en & ~req_wmode;
    arr_wmask = req_wmask;
    arr_wdata = req_wdata;
    if (init_active) begin
      arr_addr  = init_cnt[AW-1:0];
      arr_we    = 1'b1;
      arr_re    = 1'b0;
      arr_wmask = '1;
      arr_wdata = INIT_VALUE;
    end
  end

endmodule

// File: rtl/sram_array_mw_ext.sv
// Single-port masked-write SRAM with optional init sweep, 1- or 2-cycle read latency
// and selectable hold/zero behaviour of the read data between pulses.
module sram_array_mw_ext
  import sram_array_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int DATA_WIDTH = 8,
  parameter int MASK_GRAN = 8,
  parameter int READ_LATENCY = 1,
  parameter int HOLD_RDATA = 1,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int AW = calc_aw(DEPTH),
  localparam int MW = calc_mw(DATA_WIDTH, MASK_GRAN)
) (
  input  logic                  RW0_clk,
  input  logic                  reset,
  input  logic [AW-1:0]         RW0_addr,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [MW-1:0]         RW0_wmask,
  input  logic [DATA_WIDTH-1:0] RW0_wdata,
  output logic [DATA_WIDTH-1:0] RW0_rdata,
  output logic                  RW0_rvalid,
  output logic                  init_done
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0]         arr_addr;
  logic                  arr_we;
  logic                  arr_re;
  logic [MW-1:0]         arr_wmask;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  addr_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  ret_valid;
  logic [DATA_WIDTH-1:0] ret_data;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  sram_array_init_ctrl #(
    .DEPTH        (DEPTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .MASK_GRAN    (MASK_GRAN),
    .INIT_ON_RESET(INIT_ON_RESET),
    .INIT_VALUE   (INIT_VALUE)
  ) u_init_ctrl (
    .RW0_clk  (RW0_clk),
    .reset    (reset),
    .req_addr (RW0_addr),
    .req_en   (RW0_en),
    .req_wmode(RW0_wmode),
    .req_wmask(RW0_wmask),
    .req_wdata(RW0_wdata),
    .arr_addr (arr_addr),
    .arr_we   (arr_we),
    .arr_re   (arr_re),
    .arr_wmask(arr_wmask),
    .arr_wdata(arr_wdata),
    .init_done(init_done)
  );

  // Out-of-range addresses never touch storage and read back as zero.
  assign addr_ok = ({1'b0, arr_addr} < DEPTH_W);
  assign rd_word = addr_ok ? ram[arr_addr] : '0;

  always_ff @(posedge RW0_clk) begin
    for (int k = 0; k < MW; k++) begin
      if (arr_we && addr_ok && arr_wmask[k]) begin
        ram[arr_addr][k*MASK_GRAN +: MASK_GRAN] <= arr_wdata[k*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      // Word is snapshotted one edge early so a write right behind the read cannot leak in.
      logic                  p1_valid;
      logic [DATA_WIDTH-1:0] p1_data;

      always_ff @(posedge RW0_clk or posedge reset) begin
        if (reset) begin
          p1_valid <= 1'b0;
          p1_data  <= '0;
        end else begin
          p1_valid <= arr_re;
          if (arr_re) begin
            p1_data <= rd_word;
          end
        end
      end

      assign ret_valid = p1_valid;
      assign ret_data  = p1_data;
    end else begin : g_lat1
      assign ret_valid = arr_re;
      assign ret_data  = rd_word;
    end
  endgenerate

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      RW0_rvalid <= 1'b0;
      RW0_rdata  <= '0;
    end else begin
      RW0_rvalid <= ret_valid;
      if (ret_valid) begin
        RW0_rdata <= ret_data;
      end else if (HOLD_RDATA == 0) begin
        RW0_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_array_mw_ext.sv
// Drives two differently configured arrays from one request stream and checks both
// against a per-cycle behavioural model plus hand-computed scenario results.
module tb_sram_array_mw_ext;

  localparam int DEPTH_OF [2] = '{100, 128};
  localparam int RL_OF    [2] = '{2, 1};
  localparam int HOLD_OF  [2] = '{1, 0};
  localparam int LANES_OF [2] = '{4, 1};

  typedef struct {
    int          id;
    longint      due;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  addr = '0;
  logic        en = 1'b0;
  logic        wmode = 1'b0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata_a;
  logic        rvalid_a;
  logic        done_a;
  logic [7:0]  rdata_b;
  logic        rvalid_b;
  logic        done_b;

  int          tests_run = 0;
  int          tests_failed = 0;

  longint      tick = 0;
  int          since [2];
  logic        exp_v [2];
  logic [31:0] exp_d [2];
  logic [31:0] mem [2][128];
  rd_t         pend [$];

  always #5 clk = ~clk;

  sram_array_mw_ext #(
    .DEPTH(100), .DATA_WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(2),
    .HOLD_RDATA(1), .INIT_ON_RESET(1), .INIT_VALUE(32'h0)
  ) dut_a (
    .RW0_clk(clk), .reset(reset), .RW0_addr(addr), .RW0_en(en),
    .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
    .RW0_rdata(rdata_a), .RW0_rvalid(rvalid_a), .init_done(done_a)
  );

  sram_array_mw_ext #(
    .DEPTH(128), .DATA_WIDTH(8), .MASK_GRAN(8), .READ_LATENCY(1),
    .HOLD_RDATA(0), .INIT_ON_RESET(1), .INIT_VALUE(8'h0)
  ) dut_b (
    .RW0_clk(clk), .reset(reset), .RW0_addr(addr), .RW0_en(en),
    .RW0_wmode(wmode), .RW0_wmask(wmask[0:0]), .RW0_wdata(wdata[7:0]),
    .RW0_rdata(rdata_b), .RW0_rvalid(rvalid_b), .init_done(done_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic w, input logic [6:0] a,
                               input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    en = e; wmode = w; addr = a; wmask = m; wdata = d;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
  endtask

  // Model: a request is taken only once the array has been ready for a full cycle count
  // of DEPTH+1 since reset release; a read is due RL-1 edges after the edge that samples it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        since[i] = 0;
        exp_v[i] = 1'b0;
        exp_d[i] = '0;
        for (int a = 0; a < 128; a++) mem[i][a] = '0;
      end
      pend.delete();
    end else begin
      tick++;
      for (int i = 0; i < 2; i++) begin
        logic        ready;
        logic        found;
        logic [31:0] v;
        ready = (since[i] >= DEPTH_OF[i] + 1);
        if (ready && en && !wmode) begin
          v = (int'(addr) < DEPTH_OF[i]) ? mem[i][addr] : 32'h0;
          pend.push_back(rd_t'{id: i, due: tick + longint'(RL_OF[i]) - 1, data: v});
        end
        if (ready && en && wmode && int'(addr) < DEPTH_OF[i]) begin
          for (int k = 0; k < LANES_OF[i]; k++) begin
            if (wmask[k]) mem[i][addr][k*8 +: 8] = wdata[k*8 +: 8];
          end
        end
        if (since[i] <= DEPTH_OF[i]) since[i]++;
        found = 1'b0;
        v = '0;
        for (int j = 0; j < pend.size(); j++) begin
          if (pend[j].id == i && pend[j].due == tick) begin
            found = 1'b1;
            v = pend[j].data;
            pend.delete(j);
            break;
          end
        end
        exp_v[i] = found;
        if (found) exp_d[i] = v;
        else if (HOLD_OF[i] == 0) exp_d[i] = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("A rvalid", {31'b0, rvalid_a}, {31'b0, exp_v[0]});
      checkOutput("A rdata", rdata_a, exp_d[0]);
      checkOutput("A init_done", {31'b0, done_a}, {31'b0, since[0] >= DEPTH_OF[0] + 1});
      checkOutput("B rvalid", {31'b0, rvalid_b}, {31'b0, exp_v[1]});
      checkOutput("B rdata", {24'b0, rdata_b}, exp_d[1]);
      checkOutput("B init_done", {31'b0, done_b}, {31'b0, since[1] >= DEPTH_OF[1] + 1});
    end
  end

  task automatic release_and_wait(input logic poke);
    int n = 0;
    int na = 0;
    int nb = 0;
    @(negedge clk);
    reset = 1'b0;
    if (poke) begin
      en = 1'b1; wmode = 1'b1; addr = 7'd0; wmask = 4'hF; wdata = 32'h5A5A5A5A;
    end
    while ((na == 0 || nb == 0) && n < 300) begin
      @(posedge clk);
      n++;
      #1;
      en = 1'b0; wmode = 1'b0;
      if (done_a && na == 0) na = n;
      if (done_b && nb == 0) nb = n;
    end
    checkOutput("A init latency", 32'(na), 32'd101);
    checkOutput("B init latency", 32'(nb), 32'd129);
  endtask

  task automatic check_pair(input string name, input logic v, input logic [31:0] d,
                            input logic ev, input logic [31:0] ed);
    checkOutput({name, " valid"}, {31'b0, v}, {31'b0, ev});
    checkOutput({name, " data"}, d, ed);
  endtask

  initial begin
    #100000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_pair("reset A", rvalid_a, rdata_a, 1'b0, 32'h0);
    check_pair("reset B", rvalid_b, {24'b0, rdata_b}, 1'b0, 32'h0);
    checkOutput("reset A init_done", {31'b0, done_a}, 32'h0);
    release_and_wait(1'b0);

    // Back-to-back sweep of every address; freshly initialised words read as zero.
    for (int a = 0; a < 128; a++) applyStimulus(1'b1, 1'b0, 7'(a), 4'h0, 32'h0);
    repeat (3) idle();

    applyStimulus(1'b1, 1'b1, 7'd5, 4'hF, 32'hAABBCCDD);
    applyStimulus(1'b1, 1'b1, 7'd5, 4'h5, 32'h11223344);
    applyStimulus(1'b1, 1'b0, 7'd5, 4'h0, 32'h0);
    idle();
    check_pair("B masked read", rvalid_b, {24'b0, rdata_b}, 1'b1, 32'h44);
    idle();
    check_pair("A masked read", rvalid_a, rdata_a, 1'b1, 32'hAA22CC44);

    applyStimulus(1'b1, 1'b1, 7'd3, 4'hF, 32'h10);
    applyStimulus(1'b1, 1'b0, 7'd3, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 7'd3, 4'hF, 32'h20);
    applyStimulus(1'b1, 1'b0, 7'd3, 4'h0, 32'h0);
    check_pair("A lat2 snapshot", rvalid_a, rdata_a, 1'b1, 32'h10);
    idle();
    check_pair("A lat2 gap", rvalid_a, rdata_a, 1'b0, 32'h10);
    idle();
    check_pair("A lat2 new", rvalid_a, rdata_a, 1'b1, 32'h20);

    applyStimulus(1'b1, 1'b1, 7'd99, 4'hF, 32'h99);
    applyStimulus(1'b1, 1'b1, 7'd110, 4'hF, 32'h55);
    applyStimulus(1'b1, 1'b0, 7'd110, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 7'd99, 4'h0, 32'h0);
    check_pair("B addr110", rvalid_b, {24'b0, rdata_b}, 1'b1, 32'h55);
    idle();
    check_pair("A out of range", rvalid_a, rdata_a, 1'b1, 32'h0);
    idle();
    check_pair("A addr99 intact", rvalid_a, rdata_a, 1'b1, 32'h99);

    applyStimulus(1'b1, 1'b1, 7'd7, 4'hF, 32'h7E);
    applyStimulus(1'b1, 1'b0, 7'd7, 4'h0, 32'h0);
    idle();
    check_pair("B 7E pulse", rvalid_b, {24'b0, rdata_b}, 1'b1, 32'h7E);
    for (int c = 0; c < 3; c++) begin
      idle();
      check_pair("B zero idle", rvalid_b, {24'b0, rdata_b}, 1'b0, 32'h0);
      if (c == 0) check_pair("A 7E pulse", rvalid_a, rdata_a, 1'b1, 32'h7E);
      else check_pair("A hold idle", rvalid_a, rdata_a, 1'b0, 32'h7E);
    end

    // Reset with a read in flight, then again 40 words into the init sweep.
    applyStimulus(1'b1, 1'b0, 7'd3, 4'h0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_pair("abort A", rvalid_a, rdata_a, 1'b0, 32'h0);
    check_pair("abort B", rvalid_b, {24'b0, rdata_b}, 1'b0, 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid-init A init_done", {31'b0, done_a}, 32'h0);
    checkOutput("mid-init B rvalid", {31'b0, rvalid_b}, 32'h0);
    release_and_wait(1'b1);
    applyStimulus(1'b1, 1'b0, 7'd0, 4'h0, 32'h0);
    idle();
    check_pair("B dropped write", rvalid_b, {24'b0, rdata_b}, 1'b1, 32'h0);
    idle();
    check_pair("A dropped write", rvalid_a, rdata_a, 1'b1, 32'h0);

    for (int r = 0; r < 600; r++) begin
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                    7'($urandom_range(0, 127)), 4'($urandom), $urandom);
    end
    repeat (4) idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
